// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID error front end and its accumulator.
package pid_pkg;

  localparam int UNSIGNED_WIDTH_DEF = 8;
  localparam int INTEGRAL_WIDTH_DEF = 12;

  // EMPTY: no previous error held yet, so the derivative is forced to zero.
  // PRIMED: prev_err is valid and the derivative is a true first difference.
  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } pid_state_t;

  // Adds a signed increment into a signed accumulator and clamps the result to
  // the range of an iw-bit two's complement value. Operands arrive sign-extended
  // to 32 bits, so the sum cannot wrap for any iw up to 30.
  function automatic logic signed [31:0] sat_add_signed(
    input logic signed [31:0] acc,
    input logic signed [31:0] inc,
    input int                 iw
  );
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sum = acc + inc;
    hi  = (32'sd1 <<< (iw - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (iw - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/saturating_accumulator_signed.sv
// Signed accumulator that clamps at its two's complement limits instead of
// wrapping. The clamp carries no windup memory: an increment of the opposite
// sign moves the value off the rail in the same update.
module saturating_accumulator_signed
  import pid_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int INC_WIDTH = 9
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        clear_in,
  input  logic                        en_in,
  input  logic signed [INC_WIDTH-1:0] inc_in,
  output logic signed [WIDTH-1:0]     acc_out,
  output logic                        sat_out
);

  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] acc_d;

  // Next accumulator value: widen both operands, add, clamp, narrow back.
  always_comb begin
    acc_d = WIDTH'(sat_add_signed(32'(acc_out), 32'(inc_in), WIDTH));
  end

  // Accumulator register; clear wins over an enabled update. The sat flag
  // reflects the value being stored, so it is exact in the same cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_out <= '0;
      sat_out <= 1'b0;
    end else if (clear_in) begin
      acc_out <= '0;
      sat_out <= 1'b0;
    end else if (en_in) begin
      acc_out <= acc_d;
      sat_out <= (acc_d == MAX_V) || (acc_d == MIN_V);
    end
  end

endmodule

// File: rtl/pid_error_tracker.sv
// PID front end: turns an unsigned setpoint/measurement pair into signed
// error, saturating integral and first-difference derivative terms.
//
// Handshake: there is no backpressure. sample_valid_in is a one-cycle strobe
// and inputs are taken in any cycle where it is high (one sample per cycle at
// most); valid_out pulses for exactly one cycle two cycles later, and all data
// outputs change only on that pulse (or on clear/reset) and hold otherwise.
module pid_error_tracker
  import pid_pkg::*;
#(
  parameter int UNSIGNED_WIDTH = UNSIGNED_WIDTH_DEF,
  parameter int INTEGRAL_WIDTH = INTEGRAL_WIDTH_DEF
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [UNSIGNED_WIDTH-1:0]        setpoint_in,
  input  logic [UNSIGNED_WIDTH-1:0]        measured_in,
  input  logic                             sample_valid_in,
  input  logic                             clear_in,
  output logic signed [UNSIGNED_WIDTH:0]   error_out,
  output logic signed [INTEGRAL_WIDTH-1:0] integral_out,
  output logic signed [UNSIGNED_WIDTH+1:0] derivative_out,
  output logic                             integral_sat_out,
  output logic                             valid_out,
  output pid_state_t                       state_dbg_out
);

  localparam int EW = UNSIGNED_WIDTH + 1;
  localparam int DW = UNSIGNED_WIDTH + 2;

  logic signed [EW-1:0] err_s1;
  logic                 v_s1;
  logic signed [EW-1:0] prev_err;
  pid_state_t           state_q;
  pid_state_t           state_d;
  logic signed [DW-1:0] deriv_d;
  logic                 stage2_go;

  // A staged sample is committed only if no clear lands on its update cycle.
  assign stage2_go     = v_s1 && !clear_in;
  assign state_dbg_out = state_q;

  // Stage 1: zero-extend and subtract; W+1 bits hold +/-(2^W-1) exactly.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      err_s1 <= '0;
      v_s1   <= 1'b0;
    end else if (clear_in) begin
      err_s1 <= '0;
      v_s1   <= 1'b0;
    end else begin
      v_s1 <= sample_valid_in;
      if (sample_valid_in) begin
        err_s1 <= {1'b0, setpoint_in} - {1'b0, measured_in};
      end
    end
  end

  // FSM next state and derivative: zero until a previous error exists.
  always_comb begin
    state_d = state_q;
    deriv_d = '0;
    if (clear_in) begin
      state_d = EMPTY;
    end else if (v_s1) begin
      state_d = PRIMED;
      if (state_q == PRIMED) begin
        deriv_d = {err_s1[EW-1], err_s1} - {prev_err[EW-1], prev_err};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 2: register error/derivative, remember the error, pulse valid.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_err       <= '0;
      error_out      <= '0;
      derivative_out <= '0;
      valid_out      <= 1'b0;
    end else if (clear_in) begin
      prev_err       <= '0;
      error_out      <= '0;
      derivative_out <= '0;
      valid_out      <= 1'b0;
    end else begin
      valid_out <= v_s1;
      if (v_s1) begin
        prev_err       <= err_s1;
        error_out      <= err_s1;
        derivative_out <= deriv_d;
      end
    end
  end

  saturating_accumulator_signed #(
    .WIDTH     (INTEGRAL_WIDTH),
    .INC_WIDTH (EW)
  ) u_integral (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (clear_in),
    .en_in    (stage2_go),
    .inc_in   (err_s1),
    .acc_out  (integral_out),
    .sat_out  (integral_sat_out)
  );

endmodule

// File: tb/tb_pid_error_tracker.sv
// Bench for pid_error_tracker: a hand-computed per-cycle vector table for the
// directed cases, and randomized strobes checked against a behavioural model.
module tb_pid_error_tracker;
  import pid_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        setpoint = '0;
  logic [7:0]        measured = '0;
  logic              sample_valid = 1'b0;
  logic              clear = 1'b0;
  logic signed [8:0]  error_out;
  logic signed [11:0] integral_out;
  logic signed [9:0]  derivative_out;
  logic              integral_sat_out;
  logic              valid_out;
  pid_state_t        state_dbg;

  always #5 clk = ~clk;

  pid_error_tracker #(.UNSIGNED_WIDTH(8), .INTEGRAL_WIDTH(12)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .setpoint_in      (setpoint),
    .measured_in      (measured),
    .sample_valid_in  (sample_valid),
    .clear_in         (clear),
    .error_out        (error_out),
    .integral_out     (integral_out),
    .derivative_out   (derivative_out),
    .integral_sat_out (integral_sat_out),
    .valid_out        (valid_out),
    .state_dbg_out    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  // {due cycle[15:0], setpoint, measured} for every accepted sample
  logic [31:0] exp_q[$];

  // behavioural model of the loop front end
  int m_err = 0;
  int m_int = 0;
  int m_der = 0;
  int m_prev = 0;
  bit m_sat = 0;
  bit m_primed = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_err = 0; m_int = 0; m_der = 0; m_prev = 0; m_sat = 0; m_primed = 0;
  endtask

  task automatic model_apply(input int sp, input int me);
    int e;
    e = sp - me;
    m_der = m_primed ? (e - m_prev) : 0;
    m_int = m_int + e;
    if (m_int > 2047) m_int = 2047;
    if (m_int < -2048) m_int = -2048;
    m_sat = (m_int == 2047) || (m_int == -2048);
    m_err = e;
    m_prev = e;
    m_primed = 1;
  endtask

  // Compare every output with the model at the current (negedge) sample point.
  task automatic check_model(input string tag);
    logic [31:0] item;
    bit exp_v;
    exp_v = 0;
    if (exp_q.size() > 0 && exp_q[0][31:16] == cyc[15:0]) begin
      item = exp_q.pop_front();
      model_apply(int'(item[15:8]), int'(item[7:0]));
      exp_v = 1;
    end
    chk({tag, " valid"},    int'(valid_out), int'(exp_v));
    chk({tag, " error"},    int'(error_out), m_err);
    chk({tag, " integral"}, int'(integral_out), m_int);
    chk({tag, " deriv"},    int'(derivative_out), m_der);
    chk({tag, " sat"},      int'(integral_sat_out), int'(m_sat));
    chk({tag, " state"},    int'(state_dbg), m_primed ? int'(PRIMED) : int'(EMPTY));
  endtask

  // ---------------- driver ----------------
  // Called just after a negedge: drive, clock once, check at the next negedge.
  task automatic cycle(input bit sv, input int sp, input int me, input bit clr, input string tag);
    sample_valid = sv;
    setpoint     = 8'(sp);
    measured     = 8'(me);
    clear        = clr;
    if (sv && !clr) exp_q.push_back({16'(cyc + 2), 8'(sp), 8'(me)});
    @(posedge clk);
    cyc++;
    if (clr) model_reset();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic pulse_reset();
    sample_valid = 0;
    clear = 0;
    #2 rst = 1'b1;
    #1;
    chk("async rst valid",    int'(valid_out), 0);
    chk("async rst error",    int'(error_out), 0);
    chk("async rst integral", int'(integral_out), 0);
    chk("async rst deriv",    int'(derivative_out), 0);
    chk("async rst sat",      int'(integral_sat_out), 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit sv; int sp; int me; bit clr;
    bit ev; int ee; int ei; int ed; bit es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sv, input int sp, input int me, input bit clr,
                              input bit ev, input int ee, input int ei, input int ed, input bit es);
    vec_t v;
    v.sv = sv; v.sp = sp; v.me = me; v.clr = clr;
    v.ev = ev; v.ee = ee; v.ei = ei; v.ed = ed; v.es = es;
    return v;
  endfunction

  initial begin
    // 1: single strobe, result one row later (two cycles after capture)
    tbl.push_back(mk(1, 100, 110, 0, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 1,  -10,  -10,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 0,  -10,  -10,    0, 0));
    // 2: derivative chains through prev_err
    tbl.push_back(mk(0,   0,   0, 1, 0,    0,    0,    0, 0));
    tbl.push_back(mk(1, 100,  90, 0, 0,    0,    0,    0, 0));
    tbl.push_back(mk(1, 100,  95, 0, 1,   10,   10,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 1,    5,   15,   -5, 0));
    tbl.push_back(mk(0,   0,   0, 1, 0,    0,    0,    0, 0));
    // 3: nine back-to-back maximum errors ride up to the clamp
    tbl.push_back(mk(1, 255,   0, 0, 0,    0,    0,    0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 255, 0, 0, 1, 255, 255 * (k + 1), 0, 0));
    tbl.push_back(mk(1,   0, 255, 0, 1,  255, 2047,    0, 1));
    tbl.push_back(mk(0,   0,   0, 0, 1, -255, 1792, -510, 0));
    tbl.push_back(mk(0,   0,   0, 1, 0,    0,    0,    0, 0));
    // 4: extremes exercise the full derivative width
    tbl.push_back(mk(1,   0, 255, 0, 0,    0,    0,    0, 0));
    tbl.push_back(mk(1, 255,   0, 0, 1, -255, -255,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 1,  255,    0,  510, 0));
    tbl.push_back(mk(0,   0,   0, 0, 0,  255,    0,  510, 0));
    // 5: clear one cycle after a strobe swallows it; next sample has deriv 0
    tbl.push_back(mk(1,  50,  40, 0, 0,  255,    0,  510, 0));
    tbl.push_back(mk(0,   0,   0, 1, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 0,    0,    0,    0, 0));
    tbl.push_back(mk(1,  30,  20, 0, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 1,   10,   10,    0, 0));
    // strobe coincident with clear is dropped
    tbl.push_back(mk(1,   1,   2, 1, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0,   0,   0, 0, 0,    0,    0,    0, 0));
  end

  // ---------------- main sequence ----------------
  initial begin
    #1;
    chk("reset valid",    int'(valid_out), 0);
    chk("reset error",    int'(error_out), 0);
    chk("reset integral", int'(integral_out), 0);
    chk("reset deriv",    int'(derivative_out), 0);
    chk("reset sat",      int'(integral_sat_out), 0);
    chk("reset state",    int'(state_dbg), int'(EMPTY));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed table: first row strobes in the first cycle after reset falls
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].sv, tbl[i].sp, tbl[i].me, tbl[i].clr, $sformatf("row%0d", i));
      chk($sformatf("row%0d tbl valid", i), int'(valid_out), int'(tbl[i].ev));
      chk($sformatf("row%0d tbl error", i), int'(error_out), tbl[i].ee);
      chk($sformatf("row%0d tbl integral", i), int'(integral_out), tbl[i].ei);
      chk($sformatf("row%0d tbl deriv", i), int'(derivative_out), tbl[i].ed);
      chk($sformatf("row%0d tbl sat", i), int'(integral_sat_out), int'(tbl[i].es));
    end

    // randomized strobes with random gaps, reset pulsed mid-run
    for (int i = 0; i < 100; i++) begin
      int gap;
      int sp;
      int me;
      if (i == 50) pulse_reset();
      gap = $urandom_range(0, 3);
      if (gap == 3) gap = 0;
      for (int g = 0; g < gap; g++) cycle(0, 0, 0, 0, "rand idle");
      if ($urandom_range(0, 2) == 0) begin
        sp = $urandom_range(200, 255);
        me = $urandom_range(0, 40);
        if ($urandom_range(0, 1) == 1) begin
          int t;
          t = sp; sp = me; me = t;
        end
      end else begin
        sp = $urandom_range(0, 255);
        me = $urandom_range(0, 255);
      end
      cycle(1, sp, me, 0, "rand");
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, "drain");
    chk("pending results", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on run time in case the main sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pid_error_tracker.md
# pid_error_tracker

Front end of the PID loop: takes an unsigned setpoint and an unsigned measurement, and produces three signed terms.
- Signed error.
- Saturating running integral.
- First-difference derivative.

It performs the unsigned→signed conversion that mirrors the downstream saturating signed+unsigned adder, which maps the signed correction back onto an unsigned actuator command. It sits between the distance-sensor sampler and the PID gain multipliers. Samples arrive at the control rate (~100 Hz strobe) on a single-cycle valid.

## Interface
- UNSIGNED_WIDTH, 8: width of setpoint and measurement.
- INTEGRAL_WIDTH, 12: width of the signed integral accumulator; must be > UNSIGNED_WIDTH+1.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- setpoint_in  input  UNSIGNED_WIDTH  unsigned target distance.
- measured_in  input  UNSIGNED_WIDTH  unsigned measured distance.
- sample_valid_in  input  1  one-cycle strobe; inputs are sampled when high.
- clear_in  input  1  synchronous clear of integral and history.
- error_out  output  UNSIGNED_WIDTH+1 (signed)  setpoint − measured.
- integral_out  output  INTEGRAL_WIDTH (signed)  saturating sum of errors.
- derivative_out  output  UNSIGNED_WIDTH+2 (signed)  error − previous error.
- integral_sat_out  output  1  high while integral_out sits at either clamp.
- valid_out  output  1  one-cycle strobe; all outputs are updated together.

## Operation
- **FSM states**
  - EMPTY: no previous error is held. Entered on reset and on clear_in.
  - PRIMED: a previous error is held.
- **Stage 1** (capture), on sample_valid_in:
  - Zero-extend both inputs to W+1 bits and subtract into err_s1.
  - Range is ±(2^W−1), so the subtraction never overflows.
- **Stage 2** (update), one cycle after stage 1:
  - Integral: integral + sign-extended err_s1, computed at INTEGRAL_WIDTH+1 bits.
  - Clamp the integral to [−2^(IW−1), 2^(IW−1)−1].
  - integral_sat_out is set iff the stored value equals either bound.
  - Derivative in EMPTY: derivative_out = 0, then transition to PRIMED.
  - Derivative in PRIMED: derivative_out = err_s1 − prev_err, at W+2 bits, exact.
  - prev_err ← err_s1; error_out ← err_s1; valid_out pulses.
- **clear_in** has priority over everything:
  - Integral, prev_err, error_out, derivative_out and integral_sat_out go to 0.
  - FSM goes to EMPTY; any in-flight stage-1 sample is discarded (no valid_out).
  - A sample_valid_in in the same cycle as clear_in is dropped.
- **Back-to-back samples**
  - sample_valid_in on consecutive cycles is legal; the pipeline accepts one sample per cycle.
  - The integral and derivative chain correctly through prev_err with no bubbles.
- Outputs hold their last values between valid_out pulses.

## Timing
- Latency: sample_valid_in in cycle N → valid_out and all outputs updated in cycle N+2 (registered outputs).
- Throughput: 1 sample/cycle.
- Reset (asynchronous, rst_in high): all outputs 0, internal registers 0, FSM = EMPTY, stage-1 valid = 0.
- Release from reset is synchronous to clk_in. The first sample is accepted in the first cycle after rst_in falls.
- Reset asserted mid-pipeline: the in-flight sample is lost, and no valid_out is produced for it.
- Clear asserted in cycle N+1 of a sample taken in N: that sample produces no valid_out.
- Saturation boundary:
  - Adding into a clamped integral with error of the same sign holds the clamp.
  - An error of the opposite sign moves the integral off the clamp in that same update (no windup memory).

## Structure
- Package pid_pkg:
  - localparams for default widths;
  - typedef of the FSM enum (EMPTY, PRIMED);
  - function sat_add_signed(acc, inc) returning the clamped INTEGRAL_WIDTH result.
- One sub-module, saturating_accumulator_signed, holding the integral register, the clamp and the sat flag. It is reusable for the motor-speed loop.
- The top level holds the stage-1 subtractor, prev_err, the FSM and the valid pipeline.

## Test plan
With UNSIGNED_WIDTH=8 and INTEGRAL_WIDTH=12:
1. Reset, then setpoint=100, measured=110, one strobe → two cycles later: error_out=−10, integral_out=−10, derivative_out=0, valid_out for exactly one cycle.
2. Strobes (100,90) then (100,95) → second result: error=5, integral=15, derivative=−5.
3. Nine consecutive strobes of (255,0) → integral 255, 510, …, 2040, then 2047. integral_sat_out rises on the ninth result; a following (0,255) gives integral 1792 with sat cleared.
4. Extremes (0,255) and then (255,0) → error −255 then 255; derivative 510, checking that the W+2 width is exact.
5. clear_in asserted one cycle after a strobe → no valid_out. All outputs read 0, and the next sample yields derivative 0.
6. 100 random (setpoint, measured) strobes at random gaps, including back-to-back, checked against a reference model. rst_in is pulsed mid-run; all outputs must be 0 immediately, asynchronously.
